coin_feeder: RTL and testbench
==============================

COIN_FEEDER -- requirements
Module: coin_feeder

Interface
REQ-001 Parameter RESP_WAIT, default 4, SHALL be the number of idle cycles to wait for sell after the last coin before timing out (range 1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 req_valid  input  1  SHALL indicate that req_seq holds a purchase request.
REQ-005 req_ready  output  1  SHALL be high only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-006 req_seq  input  10  SHALL hold five 2-bit coin slots, slot 0 = bits [1:0], sent first; codes are 00 none, 01 0.5, 10 1.0, 11 illegal.
REQ-007 coin  output  2  SHALL be the registered coin code driven to the vending machine.
REQ-008 sell  input  1  SHALL be the vending-machine sell indication.
REQ-009 change  input  2  SHALL be the vending-machine change code, valid while sell=1.
REQ-010 done  output  1  SHALL be a one-cycle pulse marking that the result outputs are valid.
REQ-011 sold  output  1  SHALL be the result flag: 1 = sell seen, 0 = timeout.
REQ-012 chg  output  2  SHALL be the change code captured with sell (00 if none).
REQ-013 paid  output  4  SHALL be the value inserted, in units of 0.5.
REQ-014 err  output  1  SHALL be set in the result if any consumed slot held code 11.

Function
REQ-015 FSM states SHALL be IDLE, FEED, WAIT and DONE; there are no other states.
REQ-016 IDLE behaviour SHALL be:
- coin=00.
- On acceptance: latch req_seq into the shift register; clear slot count, paid, err, sold and chg; go to FEED.
REQ-017 FEED, on each edge, SHALL register coin = slot[1:0], with 11 mapped to 00 and err set, then shift right by 2 and increment the slot count.
- The first coin appears on coin from the edge after acceptance.
REQ-018 paid SHALL add 1 for 01 and 2 for 10 at the edge where that coin is registered; maximum 10; no wrap.
REQ-019 FEED SHALL go to WAIT when any of these holds:
- the 5th slot has been registered;
- the remaining shift register is all zero (empty slots are not driven).
REQ-020 sell SHALL be sampled on every edge while in FEED or WAIT.
- When sampled high: capture chg=change and sold=1, register coin=00 (remaining slots dropped, not counted in paid), go to DONE.
REQ-021 A sell sampled on the same edge that would register the next coin SHALL take priority: that coin is not driven.
REQ-022 WAIT SHALL hold coin=00 and count RESP_WAIT edges.
- If sell is sampled on or before the last count, REQ-020 applies.
- Otherwise go to DONE with sold=0 and chg=00.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 sold, chg, paid and err SHALL hold their values from DONE until the next acceptance.
REQ-025 req_valid SHALL be ignored outside IDLE; a request held high across DONE is accepted in the following IDLE cycle.
REQ-026 An all-zero req_seq SHALL go FEED -> WAIT after one edge, with coin=00 throughout.

Reset
REQ-027 While rst=1 at an edge, the block SHALL enter IDLE and set coin=00, done=0, sold=0, chg=00, paid=0, err=0, and clear the shift register and counters; req_ready=1 from the next cycle.
REQ-028 Reset asserted mid-FEED or mid-WAIT SHALL abort the transaction with no done pulse.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- req_seq=00_0101_0101; bench raises sell at the 4th coin edge +1 with change=00 -> coin 01,01,01,01; done with sold=1, chg=00, paid=4, err=0.
- req_seq=00_0010_0110; sell with change=01 one edge after the 3rd coin -> coin 10,01,10; sold=1, chg=01, paid=5.
- req_seq=00_1001_0101; sell sampled on the edge after the 3rd coin -> the 4th coin (10) is never driven; paid=3; sold=1.
- req_seq=00_0000_0101; no sell, RESP_WAIT=4 -> 2 coins, then 4 WAIT edges; done with sold=0, chg=00, paid=2.
- req_seq=11_0000_0011 -> slot codes 11 drive coin=00; err=1, paid=0, sold=0 after timeout.
- rst pulsed during the 2nd FEED cycle -> coin=00 next edge, no done, req_ready=1; a new request then completes normally.

Source files
------------

// File: rtl/coin_feeder_if.sv
// coin_feeder_if - request and vending-machine signal bundle for coin_feeder.
//   req_valid/req_ready/req_seq : purchase request handshake (five 2-bit coin slots)
//   coin                        : coin code driven to the vending machine
//   sell/change                 : vending-machine response
//   done/sold/chg/paid/err      : transaction result (done is a one-cycle pulse)
// slave  = coin_feeder side, master = requester / vending-machine side.
interface coin_feeder_if;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_seq;
  logic [1:0] coin;
  logic       sell;
  logic [1:0] change;
  logic       done;
  logic       sold;
  logic [1:0] chg;
  logic [3:0] paid;
  logic       err;

  modport slave (
    input  req_valid, req_seq, sell, change,
    output req_ready, coin, done, sold, chg, paid, err
  );

  modport master (
    output req_valid, req_seq, sell, change,
    input  req_ready, coin, done, sold, chg, paid, err
  );
endinterface

// File: rtl/coin_feeder.sv
// coin_feeder - feeds up to five coins from a latched request to a vending
// machine, then waits a bounded time for the sell indication and reports.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : coin_feeder_if.slave (request handshake, coin/sell/change, results)
//   RESP_WAIT : idle edges to wait for sell after the last coin (1..15)
//
// state | meaning
// IDLE  | ready for a request, coin=00
// FEED  | one slot registered onto coin per edge, sell sampled each edge
// WAIT  | coin=00, down-counting RESP_WAIT edges for sell
// DONE  | one-cycle done pulse, results valid
module coin_feeder #(
  parameter int unsigned RESP_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  coin_feeder_if.slave  bus
);

  localparam logic [3:0] WAIT_LOAD = 4'(RESP_WAIT);

  typedef enum logic [1:0] {IDLE, FEED, WAIT, DONE} state_t;

  state_t     state_q, state_d;
  logic [9:0] shreg_q, shreg_d;
  logic [2:0] cnt_q,   cnt_d;
  logic [3:0] wait_q,  wait_d;
  logic [1:0] coin_q,  coin_d;
  logic       done_q,  done_d;
  logic       sold_q,  sold_d;
  logic [1:0] chg_q,   chg_d;
  logic [3:0] paid_q,  paid_d;
  logic       err_q,   err_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    coin_d  = 2'b00;
    done_d  = 1'b0;
    sold_d  = sold_q;
    chg_d   = chg_q;
    paid_d  = paid_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          shreg_d = bus.req_seq;
          cnt_d   = 3'd0;
          paid_d  = 4'd0;
          err_d   = 1'b0;
          sold_d  = 1'b0;
          chg_d   = 2'b00;
          state_d = FEED;
        end
      end

      FEED: begin
        // sell wins over the coin that would otherwise be registered this edge
        if (bus.sell) begin
          sold_d  = 1'b1;
          chg_d   = bus.change;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          shreg_d = {2'b00, shreg_q[9:2]};
          cnt_d   = cnt_q + 3'd1;
          case (shreg_q[1:0])
            2'b01: begin
              coin_d = 2'b01;
              paid_d = paid_q + 4'd1;
            end
            2'b10: begin
              coin_d = 2'b10;
              paid_d = paid_q + 4'd2;
            end
            2'b11:   err_d = 1'b1;
            default: ;
          endcase
          // trailing empty slots are never driven
          if (cnt_q == 3'd4 || shreg_d == 10'd0) begin
            wait_d  = WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (bus.sell) begin
          sold_d  = 1'b1;
          chg_d   = bus.change;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (wait_q <= 4'd1) begin
          sold_d  = 1'b0;
          chg_d   = 2'b00;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= 10'd0;
      cnt_q   <= 3'd0;
      wait_q  <= 4'd0;
      coin_q  <= 2'b00;
      done_q  <= 1'b0;
      sold_q  <= 1'b0;
      chg_q   <= 2'b00;
      paid_q  <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      coin_q  <= coin_d;
      done_q  <= done_d;
      sold_q  <= sold_d;
      chg_q   <= chg_d;
      paid_q  <= paid_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.coin      = coin_q;
  assign bus.done      = done_q;
  assign bus.sold      = sold_q;
  assign bus.chg       = chg_q;
  assign bus.paid      = paid_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_coin_feeder.sv
// tb_coin_feeder - directed and randomized checks of coin_feeder against a
// transaction-level model (slot list, edge counts, sums).
module tb_coin_feeder;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  coin_feeder_if bus ();

  coin_feeder #(.RESP_WAIT(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] drive_code(input logic [1:0] s);
    return (s == 2'b11) ? 2'b00 : s;
  endfunction

  // One full transaction: request, per-edge coin/done checks, result checks.
  // Starts and ends at a negedge. sell_at = edge index after acceptance at
  // which sell is sampled high (0 or out of window = never).
  task automatic run_txn(input logic [9:0] seq, input int sell_at, input logic [1:0] chv,
                         input string name, output int waited, output logic [3:0] exp_paid);
    int         feed, total, done_edge, coins;
    bit         exp_sold, exp_err;
    logic [1:0] slot, exp_coin, exp_chg;

    feed = 1;
    for (int i = 0; i < 5; i++) if (seq[2*i +: 2] != 2'b00) feed = i + 1;
    total     = feed + RW;
    exp_sold  = (sell_at >= 1) && (sell_at <= total);
    done_edge = exp_sold ? sell_at : total;
    coins     = exp_sold ? ((sell_at - 1 < feed) ? sell_at - 1 : feed) : feed;
    exp_chg   = exp_sold ? chv : 2'b00;
    exp_paid  = 4'd0;
    exp_err   = 1'b0;
    for (int i = 0; i < coins; i++) begin
      slot = seq[2*i +: 2];
      if (slot == 2'b01) exp_paid = exp_paid + 4'd1;
      else if (slot == 2'b10) exp_paid = exp_paid + 4'd2;
      else if (slot == 2'b11) exp_err = 1'b1;
    end

    bus.req_valid = 1'b1;
    bus.req_seq   = seq;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 8) begin
      @(posedge clk); @(negedge clk);
      waited++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: req_ready=%b want 1", name, bus.req_ready);
    end
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_seq   = 10'($urandom);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: req_ready=%b want 0", name, bus.req_ready);
    end

    for (int k = 1; k <= done_edge; k++) begin
      bus.sell   = (k == sell_at);
      bus.change = (k == sell_at) ? chv : 2'($urandom);
      @(posedge clk); @(negedge clk);
      bus.sell = 1'b0;
      exp_coin = (k < done_edge && k <= feed) ? drive_code(seq[2*(k-1) +: 2]) : 2'b00;
      checks++;
      if (bus.coin !== exp_coin) begin
        errors++;
        $display("FAIL %s coin edge %0d: got %b want %b", name, k, bus.coin, exp_coin);
      end
      checks++;
      if (bus.done !== (k == done_edge)) begin
        errors++;
        $display("FAIL %s done edge %0d: got %b want %b", name, k, bus.done, (k == done_edge));
      end
    end

    checks++;
    if (bus.sold !== exp_sold) begin
      errors++;
      $display("FAIL %s sold: got %b want %b", name, bus.sold, exp_sold);
    end
    checks++;
    if (bus.chg !== exp_chg) begin
      errors++;
      $display("FAIL %s chg: got %b want %b", name, bus.chg, exp_chg);
    end
    checks++;
    if (bus.paid !== exp_paid) begin
      errors++;
      $display("FAIL %s paid: got %0d want %0d", name, bus.paid, exp_paid);
    end
    checks++;
    if (bus.err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b want %b", name, bus.err, exp_err);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.coin, bus.done, bus.sold, bus.chg, bus.paid, bus.err} !== 11'd0) begin
      errors++;
      $display("FAIL reset outputs: got coin=%b done=%b sold=%b chg=%b paid=%0d err=%b want all 0",
               bus.coin, bus.done, bus.sold, bus.chg, bus.paid, bus.err);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset req_ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_directed();
    int w; logic [3:0] p;
    run_txn(10'b00_0101_0101, 5, 2'b00, "four_halves", w, p);
    run_txn(10'b00_0010_0110, 4, 2'b01, "change01", w, p);
    run_txn(10'b00_1001_0101, 4, 2'b10, "sell_preempts", w, p);
    run_txn(10'b00_0000_0101, 0, 2'b11, "timeout", w, p);
    run_txn(10'b11_0000_0011, 0, 2'b00, "illegal", w, p);
    run_txn(10'b00_0000_0000, 0, 2'b00, "empty", w, p);
    run_txn(10'b10_1010_1010, 0, 2'b00, "max_paid", w, p);
    run_txn(10'b00_0000_0101, RW + 2, 2'b10, "sell_last_wait", w, p);
  endtask

  task automatic test_back_to_back();
    int w; logic [3:0] p;
    run_txn(10'b00_0001_1001, 0, 2'b00, "hold_a", w, p);
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.paid !== p || bus.sold !== 1'b0) begin
      errors++;
      $display("FAIL hold after done: got done=%b paid=%0d sold=%b want 0/%0d/0",
               bus.done, bus.paid, bus.sold, p);
    end
    run_txn(10'b00_0000_0110, 2, 2'b11, "hold_b", w, p);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL idle accept wait: got %0d want 0", w);
    end
    run_txn(10'b01_0101_1010, 3, 2'b01, "b2b", w, p);
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL b2b accept wait: got %0d want 1", w);
    end
  endtask

  task automatic test_reset_mid_feed();
    int w; logic [3:0] p; bit saw_done;
    bus.req_valid = 1'b1;
    bus.req_seq   = 10'b10_1010_1010;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.coin !== 2'b10) begin
      errors++;
      $display("FAIL rst_mid first coin: got %b want 10", bus.coin);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.coin !== 2'b00 || bus.done !== 1'b0 || bus.req_ready !== 1'b1 || bus.paid !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid state: got coin=%b done=%b ready=%b paid=%0d want 00/0/1/0",
               bus.coin, bus.done, bus.req_ready, bus.paid);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.done === 1'b1 || bus.coin !== 2'b00) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL rst_mid aborted: got activity=1 want 0");
    end
    run_txn(10'b00_0001_0110, 0, 2'b00, "after_rst", w, p);
  endtask

  task automatic test_random();
    int w; logic [3:0] p; logic [9:0] seq; int sa;
    for (int n = 0; n < 40; n++) begin
      seq = 10'($urandom);
      if (n % 5 == 0) seq = seq & 10'b00_0011_1111;
      sa = int'($urandom_range(0, 12));
      run_txn(seq, sa, 2'($urandom), "random", w, p);
      checks++;
      if (w !== 1) begin
        errors++;
        $display("FAIL random accept wait %0d: got %0d want 1", n, w);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_seq   = 10'd0;
    bus.sell      = 1'b0;
    bus.change    = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    @(posedge clk); @(negedge clk);
    test_reset_mid_feed();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
